// File: rtl/mem_sequencer_pkg.sv
// mem_sequencer_pkg: state encoding, buffer sizing and
// default widths shared by the frame buffer sequencer.
package mem_sequencer_pkg;

  localparam int DEF_NB_ADDRESS = 10;
  localparam int DEF_RAM_WIDTH  = 13;

  localparam int BUF_DEPTH = 4;
  localparam int BUF_AW    = 2;
  localparam int BUF_CW    = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2,
    ST_READ = 2'd3
  } state_t;

endpackage

// File: rtl/mem_seq_out_fifo.sv
// mem_seq_out_fifo: 4-entry output buffer that absorbs
// words returning from the RAM read port.
module mem_seq_out_fifo
  import mem_sequencer_pkg::*;
#(
  parameter int W = DEF_RAM_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [W-1:0]      din,
  output logic [W-1:0]      dout,
  output logic [BUF_CW-1:0] occ
);

  logic [W-1:0]      mem [BUF_DEPTH];
  logic [BUF_AW-1:0] wp;
  logic [BUF_AW-1:0] rp;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & (occ != BUF_CW'(BUF_DEPTH));
  assign do_pop  = pop & (occ != '0);
  assign dout    = mem[rp];

  // Storage, pointers and occupancy; reset leaves the head at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= wp + BUF_AW'(1);
      end
      if (do_pop) begin
        rp <= rp + BUF_AW'(1);
      end
      if (do_push && !do_pop) begin
        occ <= occ + BUF_CW'(1);
      end else if (!do_push && do_pop) begin
        occ <= occ - BUF_CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer: loads a frame into block RAM, then streams it back.
// Optional MEM_SEQ_REPLAY_EN adds i_clear and frame replay from FULL.
module mem_sequencer
  import mem_sequencer_pkg::*;
#(
  parameter int NB_ADDRESS = DEF_NB_ADDRESS,
  parameter int RAM_WIDTH  = DEF_RAM_WIDTH
) (
  input  logic                  i_CLK,
  input  logic                  i_rst_n,
  input  logic [NB_ADDRESS-1:0] i_frame_len,
  input  logic                  i_load_valid,
  input  logic [RAM_WIDTH-1:0]  i_load_data,
  output logic                  o_load_ready,
  input  logic                  i_start,
`ifdef MEM_SEQ_REPLAY_EN
  input  logic                  i_clear,
`endif
  output logic                  o_rd_valid,
  output logic [RAM_WIDTH-1:0]  o_rd_data,
  input  logic                  i_rd_ready,
  output logic                  o_mem_wrEnable,
  output logic [NB_ADDRESS-1:0] o_mem_writeAdd,
  output logic [RAM_WIDTH-1:0]  o_mem_data,
  output logic [NB_ADDRESS-1:0] o_mem_readAdd,
  input  logic [RAM_WIDTH-1:0]  i_mem_data,
  output logic                  o_busy,
  output logic                  o_done
);

  state_t                state;
  logic [NB_ADDRESS-1:0] last_idx;
  logic [NB_ADDRESS-1:0] wr_cnt;
  logic [NB_ADDRESS-1:0] rd_addr;
  logic [NB_ADDRESS-1:0] out_cnt;
  logic                  issue_done;
  logic                  inflight;
  logic [BUF_CW-1:0]     occ;
  logic [3:0]            pending;
  logic                  accept;
  logic                  issue;
  logic                  pop;
  logic                  last_out;

  // last_idx = len-1, so a length field of 0 wraps to all-ones.
  assign accept   = i_load_valid & o_load_ready;
  assign pending  = {1'b0, occ} + {3'b0, inflight};
  assign issue    = (state == ST_READ) & ~issue_done
                  & (pending < 4'(BUF_DEPTH));
  assign o_rd_valid    = (occ != '0);
  assign pop           = o_rd_valid & i_rd_ready;
  assign last_out      = pop & (state == ST_READ)
                       & (out_cnt == last_idx);
  assign o_done        = last_out;
  assign o_busy        = (state != ST_IDLE);
  assign o_mem_readAdd = rd_addr;

  mem_seq_out_fifo #(
    .W(RAM_WIDTH)
  ) u_fifo (
    .clk  (i_CLK),
    .rst_n(i_rst_n),
    .push (inflight),
    .pop  (pop),
    .din  (i_mem_data),
    .dout (o_rd_data),
    .occ  (occ)
  );

  // Frame FSM with registered write port and read address issue.
  always_ff @(posedge i_CLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      o_load_ready   <= 1'b0;
      o_mem_wrEnable <= 1'b0;
      o_mem_writeAdd <= '0;
      o_mem_data     <= '0;
      last_idx       <= '0;
      wr_cnt         <= '0;
      rd_addr        <= '0;
      out_cnt        <= '0;
      issue_done     <= 1'b0;
      inflight       <= 1'b0;
    end else begin
      o_mem_wrEnable <= accept;
      if (accept) begin
        o_mem_writeAdd <= wr_cnt;
        o_mem_data     <= i_load_data;
      end
      inflight <= issue;
      if (issue) begin
        if (rd_addr == last_idx) begin
          issue_done <= 1'b1;
        end else begin
          rd_addr <= rd_addr + NB_ADDRESS'(1);
        end
      end
      if (pop && state == ST_READ) begin
        out_cnt <= out_cnt + NB_ADDRESS'(1);
      end
      unique case (state)
        ST_IDLE: begin
          o_load_ready <= 1'b1;
          if (accept) begin
            last_idx <= i_frame_len - NB_ADDRESS'(1);
            wr_cnt   <= NB_ADDRESS'(1);
            if (i_frame_len == NB_ADDRESS'(1)) begin
              state        <= ST_FULL;
              o_load_ready <= 1'b0;
              wr_cnt       <= '0;
            end else begin
              state <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (wr_cnt == last_idx) begin
              state        <= ST_FULL;
              o_load_ready <= 1'b0;
              wr_cnt       <= '0;
            end else begin
              wr_cnt <= wr_cnt + NB_ADDRESS'(1);
            end
          end
        end
        ST_FULL: begin
`ifdef MEM_SEQ_REPLAY_EN
          if (i_clear) begin
            state        <= ST_IDLE;
            o_load_ready <= 1'b1;
          end else
`endif
          if (i_start) begin
            state      <= ST_READ;
            rd_addr    <= '0;
            out_cnt    <= '0;
            issue_done <= 1'b0;
          end
        end
        ST_READ: begin
          if (last_out) begin
`ifdef MEM_SEQ_REPLAY_EN
            state <= ST_FULL;
`else
            state        <= ST_IDLE;
            o_load_ready <= 1'b1;
`endif
            rd_addr    <= '0;
            out_cnt    <= '0;
            issue_done <= 1'b0;
            wr_cnt     <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: directed scoreboard bench with a behavioural
// RAM; define MEM_SEQ_REPLAY_EN to also cover frame replay.
`timescale 1ns/1ps
module tb_mem_sequencer;

  localparam int NA = 10;
  localparam int RW = 13;
`ifdef MEM_SEQ_REPLAY_EN
  localparam bit REPLAY = 1'b1;
`else
  localparam bit REPLAY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NA-1:0] frame_len = '0;
  logic          load_valid = 1'b0;
  logic [RW-1:0] load_data = '0;
  logic          load_ready;
  logic          start = 1'b0;
  logic          clear = 1'b0;
  logic          rd_valid;
  logic [RW-1:0] rd_data;
  logic          rd_ready = 1'b0;
  logic          wr_en;
  logic [NA-1:0] wr_add;
  logic [RW-1:0] wr_data;
  logic [NA-1:0] rd_add;
  logic [RW-1:0] mem_q;
  logic          busy;
  logic          done;

  logic [RW-1:0]    ram [1<<NA];
  logic [RW-1:0]    sbq [$];
  logic [NA+RW-1:0] wq  [$];
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) ram[wr_add] <= wr_data;
    mem_q <= ram[rd_add];
  end

  mem_sequencer dut (
    .i_CLK         (clk),
    .i_rst_n       (rst_n),
    .i_frame_len   (frame_len),
    .i_load_valid  (load_valid),
    .i_load_data   (load_data),
    .o_load_ready  (load_ready),
    .i_start       (start),
`ifdef MEM_SEQ_REPLAY_EN
    .i_clear       (clear),
`endif
    .o_rd_valid    (rd_valid),
    .o_rd_data     (rd_data),
    .i_rd_ready    (rd_ready),
    .o_mem_wrEnable(wr_en),
    .o_mem_writeAdd(wr_add),
    .o_mem_data    (wr_data),
    .o_mem_readAdd (rd_add),
    .i_mem_data    (mem_q),
    .o_busy        (busy),
    .o_done        (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ends at +2 ns in the cycle after the last acceptance.
  task automatic load_frame(input logic [NA-1:0] flen, input int n,
                            input logic [RW-1:0] base,
                            input logic [RW-1:0] step);
    logic [NA+RW-1:0] w;
    frame_len = flen;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = base + RW'(i) * step;
      #1;
      chk("load_ready", load_ready, 1);
      sbq.push_back(load_data);
      wq.push_back({NA'(i), load_data});
      tick();
      load_valid = 1'b0;
      #1;
      chk("wr_en", wr_en, 1);
      chk("wq_nonempty", wq.size() > 0, 1);
      if (wq.size() > 0) begin
        w = wq.pop_front();
        chk("wr_add", wr_add, w[NA+RW-1:RW]);
        chk("wr_data", wr_data, w[RW-1:0]);
      end
    end
    chk("load_ready_drop", load_ready, 0);
    chk("busy_full", busy, 1);
  endtask

  // mode 0: ready high, 1: toggling, 2: long stall then toggling.
  task automatic read_frame(input int n, input int mode,
                            input bit timed);
    logic [RW-1:0] held = '0;
    logic [RW-1:0] exp;
    bit stalled = 1'b0;
    int got = 0;
    int c;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (got < n && c < 8 * n + 40) begin
      if (mode == 0) rd_ready = 1'b1;
      else if (mode == 1) rd_ready = c[0];
      else rd_ready = (c >= 12) && c[0];
      #1;
      if (stalled) begin
        chk("hold_valid", rd_valid, 1);
        chk("hold_data", rd_data, held);
      end
      stalled = rd_valid && !rd_ready;
      held = rd_data;
      if (rd_valid && rd_ready) begin
        chk("sb_nonempty", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          exp = sbq.pop_front();
          chk("rd_data", rd_data, exp);
        end
        if (timed) chk("rd_cycle", c, got + 3);
        chk("done_last", done, got == n - 1);
        got++;
      end else begin
        chk("done_quiet", done, 0);
      end
      tick();
      c++;
    end
    rd_ready = 1'b0;
    chk("read_count", got, n);
    #1;
    chk("busy_after", busy, REPLAY);
    chk("ready_after", load_ready, !REPLAY);
  endtask

  task automatic back_to_idle();
`ifdef MEM_SEQ_REPLAY_EN
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("clear_ready", load_ready, 1);
    chk("clear_busy", busy, 0);
`endif
  endtask

  initial begin
    int k;
    logic [RW-1:0] rep [$];
    // reset values
    tick();
    tick();
    chk("rst_load_ready", load_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_add", wr_add, 0);
    chk("rst_rd_add", rd_add, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", load_ready, 1);

    // start in IDLE is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("start_idle_ignored", busy, 0);

    // len 5, then load attempt in FULL must not write
    load_frame(10'd5, 5, 13'h101, 13'h1);
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    #1;
    chk("load_in_full_ignored", wr_en, 0);
    sbq.push_back(13'h1fff);
    sbq.pop_back();
    read_frame(5, 0, 1'b1);
    back_to_idle();

    // toggling backpressure
    load_frame(10'd5, 5, 13'h111, 13'h3);
    read_frame(5, 1, 1'b0);
    back_to_idle();

    // single-word frame
    load_frame(10'd1, 1, 13'h0abc, 13'h0);
    read_frame(1, 0, 1'b1);
    back_to_idle();

    // long stall fills the buffer
    load_frame(10'd8, 8, 13'h0f00, 13'h11);
    read_frame(8, 2, 1'b0);
    back_to_idle();

    // length field 0 means a full 1024-word frame
    load_frame(10'd0, 1024, 13'h0005, 13'd37);
    read_frame(1024, 0, 1'b1);
    back_to_idle();

    // reset while the third output word is presented
    load_frame(10'd5, 5, 13'h301, 13'h1);
    start = 1'b1;
    tick();
    start = 1'b0;
    rd_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 2; c++) begin
      #1;
      if (rd_valid) begin
        void'(sbq.pop_front());
        k++;
      end
      tick();
    end
    #1;
    chk("third_word_present", rd_valid, 1);
    chk("third_word_data", rd_data, 13'h303);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", load_ready, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_rd_add", rd_add, 0);
    chk("midrst_rd_data", rd_data, 0);
    rd_ready = 1'b0;
    sbq.delete();
    wq.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rerst_ready", load_ready, 1);
    load_frame(10'd3, 3, 13'h201, 13'h1);
    read_frame(3, 0, 1'b1);
    back_to_idle();

`ifdef MEM_SEQ_REPLAY_EN
    // replay: same frame twice, then clear
    load_frame(10'd4, 4, 13'h401, 13'h5);
    rep = sbq;
    read_frame(4, 0, 1'b1);
    sbq = rep;
    read_frame(4, 1, 1'b0);
    back_to_idle();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Frame-level controller for the single-write/single-read block RAM used as the convolution frame buffer. Accepts a frame of pixel words on a valid/ready load stream, writes them at sequential addresses, then, on command, reads the frame back in address order onto a valid/ready output stream toward the convolution datapath. It hides the RAM's one-cycle registered read latency behind a small output buffer, so readout sustains one word per cycle under no backpressure.

## Interface
- NB_ADDRESS, 10, RAM address width; frame buffer holds up to 2^NB_ADDRESS words
- RAM_WIDTH, 13, word width
- i_CLK  in  1  clock, all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_frame_len  in  NB_ADDRESS  frame length in words; 0 means 2^NB_ADDRESS; latched on first accepted load word
- i_load_valid  in  1  load word present
- i_load_data  in  RAM_WIDTH  load word
- o_load_ready  out  1  sequencer accepts load word
- i_start  in  1  begin readout, honoured only in FULL
- o_rd_valid  out  1  output word present
- o_rd_data  out  RAM_WIDTH  output word
- i_rd_ready  in  1  consumer accepts output word
- o_mem_wrEnable  out  1  RAM write enable
- o_mem_writeAdd  out  NB_ADDRESS  RAM write address
- o_mem_data  out  RAM_WIDTH  RAM write data
- o_mem_readAdd  out  NB_ADDRESS  RAM read address
- i_mem_data  in  RAM_WIDTH  RAM read data (valid one cycle after o_mem_readAdd is sampled)
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse when last output word is accepted

## Operation
- States: IDLE, LOAD, FULL, READ.
- IDLE: o_load_ready=1. First accepted word (valid&ready) latches i_frame_len, is written to address 0, moves to LOAD (or directly to FULL if length is 1).
- LOAD: o_load_ready=1; each accepted word writes to the next address. Acceptance of word number len moves to FULL; o_load_ready drops in the following cycle.
- FULL: o_load_ready=0. i_start=1 moves to READ; read address counter cleared.
- READ: issues read addresses 0..len-1, one per cycle while credit allows: issue only if (buffer occupancy + reads in flight) < 4. Returned words enter a 4-entry FIFO in order; FIFO head drives o_rd_valid/o_rd_data. When word len-1 is accepted: o_done pulses, state returns to IDLE, all counters cleared.
- o_rd_data holds stable while o_rd_valid=1 and i_rd_ready=0.
- Load and read phases are exclusive; no read/write address collision occurs.
- i_start outside FULL is ignored; i_load_valid outside IDLE/LOAD is ignored (no write).
- Address counters NB_ADDRESS bits; length 2^NB_ADDRESS ends at address all-ones without wrap side effects.

## Timing
- Reset values: o_load_ready=0 during reset, 1 from first cycle after deassertion; o_rd_valid=0, o_done=0, o_busy=0, o_mem_wrEnable=0, all addresses/data 0; state IDLE, FIFO empty.
- Write path registered: word accepted in cycle t appears on o_mem_wrEnable/o_mem_writeAdd/o_mem_data in cycle t+1.
- Read path: i_start high in cycle 0 -> o_mem_readAdd=0 in cycle 1 -> i_mem_data valid cycle 2 -> o_rd_valid=1 cycle 3. With i_rd_ready held high, words leave back-to-back, last word in cycle len+2, o_done in same cycle.
- Reset asserted mid-frame: immediate return to IDLE, in-flight reads and buffered words discarded, RAM contents not relied on.

## Configuration
- MEM_SEQ_REPLAY_EN: when defined, adds input i_clear (1 bit); after readout the sequencer returns to FULL instead of IDLE, so i_start replays the same frame; i_clear in FULL returns to IDLE. Without it, no i_clear port and readout always ends in IDLE.

## Structure
- Shared package: state encoding constants, buffer depth (4), default NB_ADDRESS/RAM_WIDTH.
- One sub-module: mem_seq_out_fifo, 4-entry synchronous FIFO with occupancy output, reset to empty.

## Test plan
- Load len=5 words 0x101..0x105 with continuous valid -> writes at addresses 0..4 one cycle after each acceptance, o_load_ready=0 from cycle after 5th acceptance.
- i_start in FULL, i_rd_ready=1 -> o_rd_data 0x101..0x105 on cycles 3..7, o_done in cycle 7, o_busy low cycle 8.
- Readout with i_rd_ready toggling 1/0 every cycle -> all 5 words in order, none duplicated or lost, data stable while stalled, at most 4 reads outstanding+buffered.
- i_frame_len=0 -> 1024 words accepted, addresses 0..1023, readout returns all 1024 in order.
- Reset asserted at 3rd output word -> all outputs to reset values same cycle; new load after release starts at address 0.
- With MEM_SEQ_REPLAY_EN: two i_start in succession -> identical sequences; i_clear -> IDLE, o_load_ready=1.
